bw_io_dtl_txseq: RTL and testbench
==================================

# bw_io_dtl_txseq

Transmit sequencer that sits directly upstream of the DTL pad edge logic and produces its `data` and `oe` inputs. It accepts parallel words from the core over a valid/ready handshake and buffers one word. Each word is serialized LSB-first as a framed burst: start bit, data bits, optional parity, then an output-enable turnaround. Sequencing freezes while scan is active so the edge-logic scan chain sees stable functional inputs.

## Interface
- `WIDTH`, 8: data bits per frame; legal range 2..32.
- `clk`  input  1  functional clock; same clock as the edge-logic flops.
- `reset`  input  1  asynchronous active-high reset.
- `se`  input  1  scan enable; sequencer frozen while high.
- `tx_data`  input  WIDTH  word to transmit.
- `tx_valid`  input  1  `tx_data` valid.
- `tx_ready`  output  1  hold buffer can accept; equals `~hold_full & ~se`.
- `data`  output  1  serial pad data to the edge logic; registered.
- `oe`  output  1  pad output enable to the edge logic; registered.
- `busy`  output  1  state not IDLE or hold buffer full.
- `frame_done`  output  1  one-cycle pulse, frame finished on the pad.

## Operation
- Reset values: `data`=1, `oe`=0, `frame_done`=0, `busy`=0, hold empty, state IDLE. `tx_ready` is high once `reset` is low and `se` is low.
- Accept occurs on an edge where `tx_valid & tx_ready`. `tx_data` is written to the hold register and `hold_full` is set.
- States: IDLE, START, DATA, PAR, TURN.
- IDLE: `oe`=0, `data`=1. If `hold_full`: go to START, load the shifter from hold, clear `hold_full`.
- START: `oe`=1, `data`=0 for one cycle, then go to DATA with bit index 0.
- DATA: `oe`=1, `data`=shifter[idx]; idx increments each cycle. After idx=WIDTH-1, go to PAR if parity is enabled, else go to the end-of-frame step.
- PAR: `oe`=1, `data`=even parity (XOR of the frame's WIDTH bits) for one cycle, then go to the end-of-frame step.
- End-of-frame step:
  - If `hold_full`, chain directly to START: reload the shifter, clear hold, `oe` stays 1, no TURN.
  - Otherwise go to TURN.
- TURN: `oe`=0, `data`=1 for one cycle, then IDLE.
- `frame_done` is high in the first cycle after a frame's last bit (TURN or chained START).
- Hold write and hold read on the same edge cannot occur, because `tx_ready` is low whenever hold is full.
- `se` high: state, idx, shifter, hold, `data` and `oe` all hold their values. `frame_done` is forced to 0 and `tx_ready` is 0. On `se` low, operation resumes in the same cycle state.
- `reset` asserted mid-frame: `oe` drops to 0 asynchronously, the frame and the held word are discarded, and no `frame_done` is produced.
- Bit index counter is `$clog2(WIDTH)` bits wide and never wraps past WIDTH-1.

## Timing
- Accept at edge E0 while IDLE with hold empty:
  - START is visible after E1.
  - Bit k is visible after E2+k.
  - Parity (if enabled) is visible after E2+WIDTH.
  - TURN is visible after the next edge.
  - IDLE follows one cycle later.
- Frame length on the pad is 1+WIDTH(+1) cycles with `oe`=1, followed by 1 turnaround cycle.
- Chained frames have no gap: the next START immediately follows the last bit.
- Throughput is one word per 1+WIDTH(+1) cycles with the hold buffer kept full.
- `tx_ready` rises the cycle after hold is drained, i.e. during START.
- All outputs except `tx_ready` and `busy` are flop outputs; there is no combinational path from inputs to `data`/`oe`.

## Configuration
- `BW_IO_DTL_TXSEQ_PARITY_EN` defined: the PAR state exists and one even-parity bit follows each frame's data bits.
- Undefined: no PAR state, and frames are 1+WIDTH driven cycles.

## Structure
- Package `bw_io_dtl_pkg` holds:
  - the state typedef (IDLE/START/DATA/PAR/TURN);
  - constants for the idle `data` level (1) and start-bit level (0).
- One sub-module, `bw_io_dtl_txhold`: the one-entry hold register with `hold_full` and ready generation.
- The FSM, shifter and output flops live in the top module.

## Test plan
- Reset then single word 8'hA5 with WIDTH=8 and parity off:
  - `oe` is high 9 cycles: `data` sequence 0,1,0,1,0,0,1,0,1.
  - Then one TURN cycle with `oe`=0, `data`=1.
  - `frame_done` pulses once, in the TURN cycle.
- Back-to-back 8'h01 then 8'hFF offered continuously:
  - `oe` stays high for 18 consecutive cycles, with a second start bit right after bit 7 of 8'h01.
  - Exactly two `frame_done` pulses.
- Parity enabled, word 8'h07: the ninth data cycle carries `data`=1, and `oe` is high for 10 cycles.
- `se` asserted for 5 cycles during bit 3:
  - `data`/`oe` are held at bit-3 values and `tx_ready`=0.
  - After release, bits 3..7 continue, and total driven cycles are 9+5.
- `reset` pulsed during bit 5 with hold full: `oe`=0 immediately, hold empty, no `frame_done`, and `tx_ready`=1 after release.
- `tx_valid` held high while busy: exactly one word is accepted per frame, none are dropped or duplicated, and the output order matches the input order across 4 words.

Source files
------------

// File: rtl/bw_io_dtl_pkg.sv
// Shared types and pad levels for the DTL transmit sequencer.
package bw_io_dtl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_TURN
  } txseq_state_e;

  localparam logic DATA_IDLE_LVL  = 1'b1;
  localparam logic DATA_START_LVL = 1'b0;

endpackage

// File: rtl/bw_io_dtl_txhold.sv
// One-entry hold buffer between the core handshake and the transmit shifter.
module bw_io_dtl_txhold
  import bw_io_dtl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             se,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             ready
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign ready   = ~full_q & ~se;
  assign full    = full_q;
  assign rd_data = data_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_valid && ready) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  // NOTE: the data word is reset too; it is only one register, and a known value keeps the pad free of X after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/bw_io_dtl_txseq.sv
// DTL transmit sequencer: frames buffered words LSB-first onto the pad data/oe flops.
// Optional even-parity bit per frame when BW_IO_DTL_TXSEQ_PARITY_EN is defined.
module bw_io_dtl_txseq
  import bw_io_dtl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             se,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             data,
  output logic             oe,
  output logic             busy,
  output logic             frame_done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  txseq_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             data_q, data_d;
  logic             oe_q, oe_d;
  logic             frame_done_q, frame_done_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             pop;
  logic             frame_end;

  bw_io_dtl_txhold #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .se       (se),
    .wr_data  (tx_data),
    .wr_valid (tx_valid),
    .rd_en    (pop),
    .rd_data  (hold_data),
    .full     (hold_full),
    .ready    (tx_ready)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    oe_d         = oe_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    frame_end    = 1'b0;

    if (!se) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hold_full) begin
            state_d = ST_START;
            shift_d = hold_data;
            pop     = 1'b1;
          end
        end
        ST_START: begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
        ST_DATA: begin
          if (idx_q == IDX_LAST) begin
`ifdef BW_IO_DTL_TXSEQ_PARITY_EN
            state_d = ST_PAR;
`else
            frame_end = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_PAR:  frame_end = 1'b1;
        ST_TURN: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      // A waiting word chains straight into its start bit with no turnaround.
      if (frame_end) begin
        if (hold_full) begin
          state_d = ST_START;
          shift_d = hold_data;
          pop     = 1'b1;
        end else begin
          state_d = ST_TURN;
        end
      end

      frame_done_d = frame_end;

      // Pad flops are loaded from the next state so they line up with it.
      unique case (state_d)
        ST_START: begin
          oe_d   = 1'b1;
          data_d = DATA_START_LVL;
        end
        ST_DATA: begin
          oe_d   = 1'b1;
          data_d = shift_d[idx_d];
        end
        ST_PAR: begin
          oe_d   = 1'b1;
          data_d = ^shift_d;
        end
        default: begin
          oe_d   = 1'b0;
          data_d = DATA_IDLE_LVL;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= DATA_IDLE_LVL;
      oe_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data       = data_q;
  assign oe         = oe_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_bw_io_dtl_txseq.sv
// Directed bench for bw_io_dtl_txseq; parity checks run when BW_IO_DTL_TXSEQ_PARITY_EN is defined.
module tb_bw_io_dtl_txseq;

  localparam int WIDTH = 8;
`ifdef BW_IO_DTL_TXSEQ_PARITY_EN
  localparam int FL = WIDTH + 2;
`else
  localparam int FL = WIDTH + 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             se;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             data;
  logic             oe;
  logic             busy;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] src_q[$];
  bit               oe_log[$];
  bit               data_log[$];
  bit               fd_log[$];

  bw_io_dtl_txseq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .se         (se),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .data       (data),
    .oe         (oe),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    oe_log.delete();
    data_log.delete();
    fd_log.delete();
  endtask

  task automatic offer();
    if (src_q.size() > 0) begin
      tx_data  = src_q.pop_front();
      tx_valid = 1'b1;
    end else begin
      tx_valid = 1'b0;
    end
  endtask

  // One cycle per iteration: sample at negedge, present the next word after an accepting edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit acc;
      @(negedge clk);
      oe_log.push_back(oe);
      data_log.push_back(data);
      fd_log.push_back(frame_done);
      acc = tx_valid & tx_ready;
      @(posedge clk);
      #1;
      if (acc) offer();
    end
  endtask

  function automatic int first_oe();
    for (int i = 0; i < oe_log.size(); i++) if (oe_log[i]) return i;
    return 0;
  endfunction

  function automatic int count_oe();
    int c = 0;
    foreach (oe_log[i]) c += int'(oe_log[i]);
    return c;
  endfunction

  function automatic int count_fd();
    int c = 0;
    foreach (fd_log[i]) c += int'(fd_log[i]);
    return c;
  endfunction

  function automatic logic [63:0] pack_data(input int s, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = data_log[s + i];
    return v;
  endfunction

  initial begin
    int s;
    reset    = 1'b1;
    se       = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Reset state
    #1;
    check1("rst_data", data, 1'b1);
    check1("rst_oe", oe, 1'b0);
    check1("rst_frame_done", frame_done, 1'b0);
    check1("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check1("rst_tx_ready", tx_ready, 1'b1);

`ifndef BW_IO_DTL_TXSEQ_PARITY_EN
    // Single word 8'hA5
    clear_logs();
    src_q = '{8'hA5};
    offer();
    run(16);
    s = first_oe();
    checkn("a5_oe_cycles", 64'(count_oe()), 64'd9);
    checkn("a5_data_seq", pack_data(s, 9), 64'h14A);
    check1("a5_turn_oe", oe_log[s + 9], 1'b0);
    check1("a5_turn_data", data_log[s + 9], 1'b1);
    check1("a5_turn_fd", fd_log[s + 9], 1'b1);
    checkn("a5_fd_count", 64'(count_fd()), 64'd1);
    check1("a5_idle_busy", busy, 1'b0);

    // Back-to-back 8'h01, 8'hFF
    clear_logs();
    src_q = '{8'h01, 8'hFF};
    offer();
    run(30);
    s = first_oe();
    checkn("b2b_oe_cycles", 64'(count_oe()), 64'd18);
    checkn("b2b_data_seq", pack_data(s, 18), 64'h3FC02);
    check1("b2b_chain_fd", fd_log[s + 9], 1'b1);
    check1("b2b_chain_oe", oe_log[s + 9], 1'b1);
    check1("b2b_turn_oe", oe_log[s + 18], 1'b0);
    checkn("b2b_fd_count", 64'(count_fd()), 64'd2);

    // Scan freeze during bit 3 of 8'hA5
    clear_logs();
    src_q = '{8'hA5};
    offer();
    run(6);
    se = 1'b1;
    #2;
    check1("se_tx_ready", tx_ready, 1'b0);
    run(5);
    check1("se_hold_oe", oe, 1'b1);
    check1("se_hold_data", data, 1'b0);
    check1("se_frame_done", frame_done, 1'b0);
    check1("se_busy", busy, 1'b1);
    se = 1'b0;
    run(14);
    s = first_oe();
    checkn("se_oe_cycles", 64'(count_oe()), 64'd14);
    checkn("se_data_seq", pack_data(s, 14), 64'h280A);
    checkn("se_fd_count", 64'(count_fd()), 64'd1);
`else
    // Parity frame 8'h07
    clear_logs();
    src_q = '{8'h07};
    offer();
    run(18);
    s = first_oe();
    checkn("par_oe_cycles", 64'(count_oe()), 64'd10);
    checkn("par_data_seq", pack_data(s, 9), 64'h0E);
    check1("par_bit", data_log[s + 9], 1'b1);
    check1("par_turn_oe", oe_log[s + 10], 1'b0);
    check1("par_turn_fd", fd_log[s + 10], 1'b1);
    checkn("par_fd_count", 64'(count_fd()), 64'd1);
`endif

    // Reset during bit 5 with the hold buffer full
    clear_logs();
    src_q = '{8'hA5, 8'h3C};
    offer();
    run(8);
    check1("rmid_oe_before", oe, 1'b1);
    check1("rmid_ready_before", tx_ready, 1'b0);
    tx_valid = 1'b0;
    src_q.delete();
    #2;
    reset = 1'b1;
    #1;
    check1("rmid_oe", oe, 1'b0);
    check1("rmid_data", data, 1'b1);
    check1("rmid_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    run(15);
    checkn("rmid_oe_after", 64'(count_oe()), 64'd0);
    checkn("rmid_fd_after", 64'(count_fd()), 64'd0);
    check1("rmid_ready_after", tx_ready, 1'b1);

    // tx_valid held high across four words
    clear_logs();
    src_q = '{8'h3C, 8'h96, 8'h0F, 8'hC3};
    offer();
    run(4 * FL + 12);
    s = first_oe();
    checkn("ord_oe_cycles", 64'(count_oe()), 64'(4 * FL));
    checkn("ord_word0", pack_data(s + 0 * FL + 1, WIDTH), 64'h3C);
    checkn("ord_word1", pack_data(s + 1 * FL + 1, WIDTH), 64'h96);
    checkn("ord_word2", pack_data(s + 2 * FL + 1, WIDTH), 64'h0F);
    checkn("ord_word3", pack_data(s + 3 * FL + 1, WIDTH), 64'hC3);
    checkn("ord_fd_count", 64'(count_fd()), 64'd4);
    check1("ord_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
